// File: rtl/design_09_pkg.sv
// Shared types and defaults for the design_09 arbiter slice.
package design_09_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    localparam int W_DEF   = 20;
    localparam int N_DEF   = 4;
    localparam int TMO_DEF = 64;
    localparam int ID_W    = $clog2(N_DEF);

endpackage

// File: rtl/design_09_arb_if.sv
// Client request/response and datapath-side signals of the design_09 arbiter.
interface design_09_arb_if #(
    parameter int W = 20,
    parameter int N = 4
);
    localparam int IW = $clog2(N);

    logic [N-1:0]   req;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   gnt;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [IW-1:0]  rsp_id;
    logic [W-1:0]   rsp_y;
    logic           rsp_err;
    logic           busy;
    logic           dp_start;
    logic [W-1:0]   dp_a;
    logic [W-1:0]   dp_b;
    logic [W-1:0]   dp_y;
    logic           dp_valid;

    modport master (
        input  req, req_a, req_b, rsp_ready, dp_y, dp_valid,
        output gnt, rsp_valid, rsp_id, rsp_y, rsp_err, busy,
        output dp_start, dp_a, dp_b
    );

    modport slave (
        output req, req_a, req_b, rsp_ready, dp_y, dp_valid,
        input  gnt, rsp_valid, rsp_id, rsp_y, rsp_err, busy,
        input  dp_start, dp_a, dp_b
    );

endinterface

// File: rtl/design_09_rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping at N.
module design_09_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         onehot,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);
    localparam int IW = $clog2(N);

    always_comb begin
        int j;
        logic [IW-1:0] sel;
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        j      = 0;
        sel    = '0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            sel = j[IW-1:0];
            if (!any && req[sel]) begin
                any         = 1'b1;
                idx         = sel;
                onehot[sel] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/design_09_arb.sv
// Shares one design_09 datapath among N requesters: round-robin pick,
// issue, wait for valid or timeout, then hand back a tagged response.
module design_09_arb
    import design_09_pkg::*;
#(
    parameter int W   = W_DEF,
    parameter int N   = N_DEF,
    parameter int TMO = TMO_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    design_09_arb_if.master bus
);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(TMO);

    state_e        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] id_q, id_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic          dp_start_q, dp_start_d;
    logic [W-1:0]  dp_a_q, dp_a_d;
    logic [W-1:0]  dp_b_q, dp_b_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [W-1:0]  rsp_y_q, rsp_y_d;
    logic          rsp_err_q, rsp_err_d;
    logic          busy_q, busy_d;

    logic [N-1:0]  pick_oh;
    logic [IW-1:0] pick_idx;
    logic          pick_any;

    design_09_rr_pick #(.N(N)) u_pick (
        .req    (bus.req),
        .ptr    (ptr_q),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        id_d       = id_q;
        cnt_d      = cnt_q;
        dp_a_d     = dp_a_q;
        dp_b_d     = dp_b_q;
        rsp_y_d    = rsp_y_q;
        rsp_err_d  = rsp_err_q;
        gnt_d      = '0;
        dp_start_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d    = ISSUE;
                    id_d       = pick_idx;
                    gnt_d      = pick_oh;
                    dp_start_d = 1'b1;
                    dp_a_d     = bus.req_a[int'(pick_idx) * W +: W];
                    dp_b_d     = bus.req_b[int'(pick_idx) * W +: W];
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                // A valid on the timeout cycle still counts as a result.
                if (bus.dp_valid) begin
                    state_d   = RESP;
                    rsp_y_d   = bus.dp_y;
                    rsp_err_d = 1'b0;
                end else if (cnt_q == CW'(TMO - 1)) begin
                    state_d   = RESP;
                    rsp_y_d   = '0;
                    rsp_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                    ptr_d   = (id_q == IW'(N - 1)) ? '0 : id_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        rsp_valid_d = (state_d == RESP);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            dp_start_q  <= 1'b0;
            dp_a_q      <= '0;
            dp_b_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_y_q     <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            dp_start_q  <= dp_start_d;
            dp_a_q      <= dp_a_d;
            dp_b_q      <= dp_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_y_q     <= rsp_y_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.dp_start  = dp_start_q;
    assign bus.dp_a      = dp_a_q;
    assign bus.dp_b      = dp_b_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_y     = rsp_y_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_design_09_arb.sv
// Bench for design_09_arb: directed plan steps then random traffic
// against a transaction-level round-robin/timeout model.
module tb_design_09_arb;
    localparam int W   = 20;
    localparam int N   = 4;
    localparam int TMO = 8;
    localparam int IW  = $clog2(N);

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_run  = 0;
    int   n_fail = 0;
    int   ptr_m  = 0;

    logic [N-1:0] req_v    = '0;
    logic [N-1:0] last_gnt = '0;
    logic [W-1:0] a_m [N];
    logic [W-1:0] b_m [N];

    always #5 clk = ~clk;

    design_09_arb_if #(.W(W), .N(N)) bus ();

    design_09_arb #(.W(W), .N(N), .TMO(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_m(input int p, input logic [N-1:0] m);
        int mi;
        mi = int'(m);
        for (int d = 0; d < N; d++)
            if (((mi >> ((p + d) % N)) & 1) == 1) return (p + d) % N;
        return -1;
    endfunction

    task automatic drive_ops();
        for (int i = 0; i < N; i++) begin
            bus.req_a[i*W +: W] = a_m[IW'(i)];
            bus.req_b[i*W +: W] = b_m[IW'(i)];
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_gnt"},   64'(bus.gnt),       64'd0);
        chk({tag, "_rv"},    64'(bus.rsp_valid), 64'd0);
        chk({tag, "_rid"},   64'(bus.rsp_id),    64'd0);
        chk({tag, "_ry"},    64'(bus.rsp_y),     64'd0);
        chk({tag, "_rerr"},  64'(bus.rsp_err),   64'd0);
        chk({tag, "_busy"},  64'(bus.busy),      64'd0);
        chk({tag, "_start"}, 64'(bus.dp_start),  64'd0);
        chk({tag, "_dpa"},   64'(bus.dp_a),      64'd0);
        chk({tag, "_dpb"},   64'(bus.dp_b),      64'd0);
    endtask

    task automatic do_reset();
        req_v         = '0;
        bus.req       = '0;
        bus.dp_valid  = 1'b0;
        bus.rsp_ready = 1'b0;
        rst_n         = 1'b0;
        @(negedge clk);
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        ptr_m = 0;
    endtask

    // One arbitration round from an IDLE negedge; dp_valid arrives lat_in
    // cycles after dp_start (values above TMO mean too late).
    task automatic txn(input int lat_in, input int rdy_dly);
        int            win, lat, t_rsp;
        logic [IW-1:0] wi;
        logic [N-1:0]  oh;
        logic [W-1:0]  ea, eb, ey;
        logic          eerr;
        bus.req      = req_v;
        drive_ops();
        bus.dp_valid = 1'($urandom_range(0, 1));
        bus.dp_y     = W'($urandom);
        win = rr_m(ptr_m, req_v);
        @(negedge clk);
        bus.dp_valid = 1'b0;
        last_gnt = bus.gnt;
        if (win < 0) begin
            chk("idle_gnt",  64'(bus.gnt),       64'd0);
            chk("idle_busy", 64'(bus.busy),      64'd0);
            chk("idle_rsp",  64'(bus.rsp_valid), 64'd0);
            return;
        end
        wi    = IW'(win);
        oh    = N'(1 << win);
        ea    = a_m[wi];
        eb    = b_m[wi];
        lat   = (lat_in < TMO) ? lat_in : TMO;
        eerr  = (lat_in > TMO);
        ey    = eerr ? '0 : ea + eb;
        t_rsp = 2 + lat;
        chk("gnt",      64'(bus.gnt),      64'(oh));
        chk("dp_start", 64'(bus.dp_start), 64'd1);
        chk("dp_a",     64'(bus.dp_a),     64'(ea));
        chk("dp_b",     64'(bus.dp_b),     64'(eb));
        chk("busy_iss", 64'(bus.busy),     64'd1);
        req_v[wi]    = 1'b0;
        bus.req      = req_v;
        bus.dp_valid = 1'($urandom_range(0, 1));
        bus.dp_y     = W'($urandom);
        for (int t = 2; t <= t_rsp; t++) begin
            @(negedge clk);
            if (t < t_rsp) begin
                chk("wait_rsp",   64'(bus.rsp_valid), 64'd0);
                chk("wait_start", 64'(bus.dp_start),  64'd0);
                chk("wait_gnt",   64'(bus.gnt),       64'd0);
                chk("wait_busy",  64'(bus.busy),      64'd1);
                chk("hold_a",     64'(bus.dp_a),      64'(ea));
            end else begin
                chk("rsp_valid", 64'(bus.rsp_valid), 64'd1);
                chk("rsp_id",    64'(bus.rsp_id),    64'(wi));
                chk("rsp_y",     64'(bus.rsp_y),     64'(ey));
                chk("rsp_err",   64'(bus.rsp_err),   64'(eerr));
                bus.rsp_ready = (rdy_dly == 0);
            end
            bus.dp_valid = (t == 1 + lat_in);
            bus.dp_y     = (t == 1 + lat_in) ? ea + eb : W'($urandom);
        end
        for (int r = 1; r <= rdy_dly; r++) begin
            @(negedge clk);
            bus.dp_valid = 1'b0;
            chk("bp_valid", 64'(bus.rsp_valid), 64'd1);
            chk("bp_id",    64'(bus.rsp_id),    64'(wi));
            chk("bp_y",     64'(bus.rsp_y),     64'(ey));
            chk("bp_err",   64'(bus.rsp_err),   64'(eerr));
            chk("bp_gnt",   64'(bus.gnt),       64'd0);
            chk("bp_busy",  64'(bus.busy),      64'd1);
            bus.rsp_ready = (r == rdy_dly);
        end
        @(negedge clk);
        bus.dp_valid  = 1'b0;
        bus.rsp_ready = 1'b0;
        chk("acc_valid", 64'(bus.rsp_valid), 64'd0);
        chk("acc_busy",  64'(bus.busy),      64'd0);
        ptr_m = (win + 1) % N;
    endtask

    initial begin
        logic [N-1:0] nb;
        for (int i = 0; i < N; i++) begin
            a_m[IW'(i)] = '0;
            b_m[IW'(i)] = '0;
        end
        bus.req_a = '0;
        bus.req_b = '0;
        bus.dp_y  = '0;
        do_reset();

        // single request, result 5+7 two cycles after start
        a_m[0] = W'(5);
        b_m[0] = W'(7);
        req_v  = 4'b0001;
        txn(2, 0);

        // round robin from a fresh pointer
        do_reset();
        for (int i = 0; i < N; i++) begin
            a_m[IW'(i)] = W'($urandom);
            b_m[IW'(i)] = W'($urandom);
        end
        req_v = 4'b1111;
        for (int k = 0; k < N; k++) begin
            txn(1 + k, 0);
            chk("rr_order", 64'(last_gnt), 64'(1 << k));
        end
        req_v = 4'b0101;
        txn(1, 0);
        chk("rr_0101a", 64'(last_gnt), 64'd1);
        txn(2, 0);
        chk("rr_0101b", 64'(last_gnt), 64'd4);

        // backpressure with another request pending
        req_v = 4'b0110;
        txn(3, 5);
        txn(1, 1);

        // timeouts
        req_v = 4'b1000;
        txn(99, 1);
        req_v = 4'b0001;
        txn(TMO, 0);
        req_v = 4'b0010;
        txn(TMO + 1, 2);

        // spurious valid while idle
        req_v = '0;
        repeat (3) txn(1, 0);

        // reset in the middle of WAIT
        req_v = 4'b0100;
        bus.req = req_v;
        drive_ops();
        @(negedge clk);
        req_v   = '0;
        bus.req = '0;
        @(negedge clk);
        @(negedge clk);
        chk("mw_busy", 64'(bus.busy), 64'd1);
        #2 rst_n = 1'b0;
        #1 chk_zero("mw_rst");
        @(negedge clk);
        rst_n = 1'b1;
        ptr_m = 0;
        repeat (4) begin
            @(negedge clk);
            chk("mw_norsp", 64'(bus.rsp_valid), 64'd0);
            chk("mw_idle",  64'(bus.busy),      64'd0);
        end
        req_v = 4'b0010;
        txn(2, 0);
        chk("mw_gnt", 64'(last_gnt), 64'd2);

        // random traffic
        for (int it = 0; it < 60; it++) begin
            nb = N'($urandom_range(0, (1 << N) - 1)) & ~req_v;
            for (int i = 0; i < N; i++) begin
                if (nb[IW'(i)]) begin
                    a_m[IW'(i)] = W'($urandom);
                    b_m[IW'(i)] = W'($urandom);
                end
            end
            req_v = req_v | nb;
            txn($urandom_range(1, TMO + 3), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
